// File: rtl/envelope_follower.sv
// envelope_follower
//
// Extracts a volume envelope and a gate from a signed audio stream. It is the
// analysis-side partner of the voice envelope/amplifier path.
//
// Each valid sample is rectified and reduced to an 8-bit target level. The
// target is tracked by a 16-bit accumulator with programmable attack and
// release slew. A release hold keeps the level steady for a while before it
// falls. A two-state hysteretic gate is derived from the tracked level.
//
// Pipeline for a sample presented with in_valid in cycle N:
//   N+1  magnitude / target registered
//   N+2  accumulator and level updated, level_valid pulses
//   N+3  gate updated from that level
//
// Ports
//   sample_clock   rising-edge clock for all logic
//   resetn         asynchronous active-low reset, synchronous release
//   in             signed two's-complement audio sample (BITDEPTH bits)
//   in_valid       qualifies in; the pipeline only advances on valid samples
//   attack         attack rate; the accumulator rises by attack+1 per sample
//   release_rate   release rate; the accumulator falls by release_rate+1 per
//                  sample once the hold has expired
//   threshold_on   the gate opens when level >= threshold_on
//   threshold_off  the gate closes when level < threshold_off
//   level          tracked envelope level, unsigned
//   level_valid    one-cycle pulse when level takes a new value
//   gate           hysteretic gate output

module envelope_follower #(
    parameter int BITDEPTH  = 14,
    parameter int LEVELBITS = 8,
    parameter int HOLDBITS  = 8
) (
    input  logic                       sample_clock,
    input  logic                       resetn,
    input  logic signed [BITDEPTH-1:0] in,
    input  logic                       in_valid,
    input  logic [7:0]                 attack,
    input  logic [7:0]                 release_rate,
    input  logic [7:0]                 threshold_on,
    input  logic [7:0]                 threshold_off,
    output logic [LEVELBITS-1:0]       level,
    output logic                       level_valid,
    output logic                       gate
);

    localparam int MAGBITS = BITDEPTH - 1;
    localparam int ACCBITS = LEVELBITS + 8;

    typedef enum logic {
        CLOSED = 1'b0,
        OPEN   = 1'b1
    } gate_state_t;

    // ------------------------------------------------------------------
    // Stage 1: rectification
    // ------------------------------------------------------------------
    logic [BITDEPTH-1:0]  neg_in;
    logic [MAGBITS-1:0]   mag;
    logic                 mag_unused;
    logic [LEVELBITS-1:0] target;
    logic                 stage1_valid;

    assign neg_in = BITDEPTH'(-in);

    // The most negative sample has no positive counterpart in MAGBITS bits.
    // It saturates to full scale instead of wrapping to zero.
    always_comb begin
        mag = in[MAGBITS-1:0];
        if (in[BITDEPTH-1]) begin
            if (in[MAGBITS-1:0] == '0) begin
                mag = '1;
            end else begin
                mag = neg_in[MAGBITS-1:0];
            end
        end
    end

    // Only the top LEVELBITS of the magnitude form the target.
    assign mag_unused = ^mag[MAGBITS-LEVELBITS-1:0];

    always_ff @(posedge sample_clock or negedge resetn) begin
        if (!resetn) begin
            target       <= '0;
            stage1_valid <= 1'b0;
        end else begin
            stage1_valid <= in_valid;
            if (in_valid) begin
                target <= mag[MAGBITS-1 -: LEVELBITS];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: slew-limited accumulator with release hold
    // ------------------------------------------------------------------
    logic [ACCBITS-1:0]  acc;
    logic [ACCBITS-1:0]  acc_next;
    logic [ACCBITS-1:0]  target_ext;
    logic [ACCBITS:0]    up_sum;
    logic [ACCBITS-1:0]  down_step;
    logic [ACCBITS-1:0]  down_gap;
    logic [HOLDBITS-1:0] hold;
    logic [HOLDBITS-1:0] hold_next;

    assign target_ext = {target, 8'h00};
    assign up_sum     = {1'b0, acc} + (ACCBITS+1)'(attack) + (ACCBITS+1)'(1);
    assign down_step  = ACCBITS'(release_rate) + ACCBITS'(1);
    assign down_gap   = acc - target_ext;

    // The rise is clamped at the target and the fall is clamped at the
    // target. The accumulator therefore never overshoots, so it cannot
    // wrap in either direction.
    always_comb begin
        acc_next  = acc;
        hold_next = hold;
        if (target_ext > acc) begin
            acc_next  = (up_sum > {1'b0, target_ext}) ? target_ext
                                                      : up_sum[ACCBITS-1:0];
            hold_next = '1;
        end else if (target_ext == acc) begin
            hold_next = '1;
        end else if (hold != '0) begin
            hold_next = hold - HOLDBITS'(1);
        end else begin
            acc_next = (down_gap > down_step) ? (acc - down_step) : target_ext;
        end
    end

    always_ff @(posedge sample_clock or negedge resetn) begin
        if (!resetn) begin
            acc         <= '0;
            hold        <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= stage1_valid;
            if (stage1_valid) begin
                acc  <= acc_next;
                hold <= hold_next;
            end
        end
    end

    assign level = acc[ACCBITS-1 -: LEVELBITS];

    // ------------------------------------------------------------------
    // Stage 3: hysteretic gate, evaluated once per fresh level
    // ------------------------------------------------------------------
    gate_state_t gate_state;

    // The two thresholds are compared independently per state. An inverted
    // pair (off above on) therefore still behaves predictably and may
    // toggle the gate on every sample.
    always_ff @(posedge sample_clock or negedge resetn) begin
        if (!resetn) begin
            gate_state <= CLOSED;
            gate       <= 1'b0;
        end else if (level_valid) begin
            case (gate_state)
                CLOSED: begin
                    if (level >= threshold_on) begin
                        gate_state <= OPEN;
                        gate       <= 1'b1;
                    end
                end
                OPEN: begin
                    if (level < threshold_off) begin
                        gate_state <= CLOSED;
                        gate       <= 1'b0;
                    end
                end
                default: begin
                    gate_state <= CLOSED;
                    gate       <= 1'b0;
                end
            endcase
        end
    end

endmodule
